// File: rtl/alu_16bit.sv
// Clocked 16-bit execute-stage ALU: decodes op_dec and registers the result,
// memory store word, output-port word and carry/zero flags.
module alu_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       op_dec,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] ans_ex,
    output logic [WIDTH-1:0] DM_data,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       flag_ex
);

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_ADI = 6'd2;
    localparam logic [5:0] OP_SUB = 6'd3;
    localparam logic [5:0] OP_SBI = 6'd4;
    localparam logic [5:0] OP_AND = 6'd5;
    localparam logic [5:0] OP_ANI = 6'd6;
    localparam logic [5:0] OP_OR  = 6'd7;
    localparam logic [5:0] OP_ORI = 6'd8;
    localparam logic [5:0] OP_XOR = 6'd9;
    localparam logic [5:0] OP_XRI = 6'd10;
    localparam logic [5:0] OP_NOT = 6'd11;
    localparam logic [5:0] OP_INC = 6'd12;
    localparam logic [5:0] OP_DEC = 6'd13;
    localparam logic [5:0] OP_SHL = 6'd14;
    localparam logic [5:0] OP_SHR = 6'd15;
    localparam logic [5:0] OP_SRA = 6'd16;
    localparam logic [5:0] OP_ROL = 6'd17;
    localparam logic [5:0] OP_ROR = 6'd18;
    localparam logic [5:0] OP_MOV = 6'd19;
    localparam logic [5:0] OP_MVI = 6'd20;
    localparam logic [5:0] OP_CMP = 6'd21;
    localparam logic [5:0] OP_LD  = 6'd22;
    localparam logic [5:0] OP_ST  = 6'd23;
    localparam logic [5:0] OP_OUT = 6'd24;
    localparam logic [5:0] OP_NEG = 6'd25;
    localparam logic [5:0] OP_ADC = 6'd26;
    localparam logic [5:0] OP_SBB = 6'd27;
    localparam logic [5:0] OP_MUL = 6'd28;

    logic        cin;
    logic [3:0]  sh;
    logic [16:0] shr_ext;
    logic [16:0] sra_ext;
    logic [15:0] rol_val;
    logic [15:0] ror_val;
    logic [31:0] prod;
    logic [16:0] res;
    logic        upd_r;
    logic        upd_f;

    assign cin = flag_ex[1];
    assign sh  = B[3:0];

    // Right shifts carry a guard bit below bit 0 so it ends up holding the last bit shifted out.
    assign shr_ext = {A, 1'b0} >> sh;
    assign sra_ext = $signed({A, 1'b0}) >>> sh;
    assign rol_val = (A << sh) | (A >> (5'd16 - {1'b0, sh}));
    assign ror_val = (A >> sh) | (A << (5'd16 - {1'b0, sh}));
    assign prod    = {16'h0000, A} * {16'h0000, B};

    // res[16] is the C flag for every op; res[15:0] is the result word.
    always_comb begin
        res   = '0;
        upd_r = 1'b1;
        upd_f = 1'b1;
        case (op_dec)
            OP_ADD: res = {1'b0, A} + {1'b0, B};
            OP_ADI: res = {1'b0, A} + {1'b0, data_in};
            OP_SUB: res = {1'b0, A} - {1'b0, B};
            OP_SBI: res = {1'b0, A} - {1'b0, data_in};
            OP_AND: res = {1'b0, A & B};
            OP_ANI: res = {1'b0, A & data_in};
            OP_OR:  res = {1'b0, A | B};
            OP_ORI: res = {1'b0, A | data_in};
            OP_XOR: res = {1'b0, A ^ B};
            OP_XRI: res = {1'b0, A ^ data_in};
            OP_NOT: res = {1'b0, ~A};
            OP_INC: res = {1'b0, A} + 17'd1;
            OP_DEC: res = {1'b0, A} - 17'd1;
            OP_SHL: res = {1'b0, A} << sh;
            OP_SHR: res = {shr_ext[0], shr_ext[16:1]};
            OP_SRA: res = {sra_ext[0], sra_ext[16:1]};
            OP_ROL: res = {1'b0, rol_val};
            OP_ROR: res = {1'b0, ror_val};
            OP_MOV: res = {1'b0, B};
            OP_MVI: res = {1'b0, data_in};
            OP_CMP: begin
                res   = {1'b0, A} - {1'b0, B};
                upd_r = 1'b0;
            end
            OP_LD:  res = {1'b0, data_in};
            OP_NEG: res = 17'd0 - {1'b0, A};
            OP_ADC: res = {1'b0, A} + {1'b0, B} + {16'h0000, cin};
            OP_SBB: res = {1'b0, A} - {1'b0, B} - {16'h0000, cin};
            OP_MUL: res = {|prod[31:16], prod[15:0]};
            default: begin
                upd_r = 1'b0;
                upd_f = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_ex   <= '0;
            DM_data  <= '0;
            data_out <= '0;
            flag_ex  <= '0;
        end else begin
            if (upd_r) ans_ex <= res[15:0];
            if (upd_f) flag_ex <= {res[16], res[15:0] == 16'h0000};
            if (op_dec == OP_ST)  DM_data  <= A;
            if (op_dec == OP_OUT) data_out <= A;
        end
    end

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed test-plan steps followed by
// randomized ops checked against an arithmetic reference model.
module tb_alu_16bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A, B, data_in;
    logic [5:0]  op_dec;
    logic [15:0] ans_ex, DM_data, data_out;
    logic [1:0]  flag_ex;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    logic [15:0] m_ans, m_dm, m_out;
    logic        m_c, m_z;

    alu_16bit #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .op_dec   (op_dec),
        .data_in  (data_in),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .data_out (data_out),
        .flag_ex  (flag_ex)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ans = '0; m_dm = '0; m_out = '0; m_c = 1'b0; m_z = 1'b0;
    endfunction

    // Reference: plain unsigned integer arithmetic on the operand values.
    function automatic void model_step(input int unsigned op, input int unsigned a,
                                       input int unsigned b, input int unsigned d);
        int unsigned r  = 0;
        int unsigned n  = b & 15;
        int unsigned ci = m_c ? 1 : 0;
        int          s;
        longint unsigned p;
        bit wr = 1'b1, fl = 1'b1, c = 1'b0;
        case (op)
            1:  begin r = a + b;      c = (r > 65535); end
            2:  begin r = a + d;      c = (r > 65535); end
            12: begin r = a + 1;      c = (r > 65535); end
            26: begin r = a + b + ci; c = (r > 65535); end
            3:  begin r = a - b;      c = (a < b); end
            4:  begin r = a - d;      c = (a < d); end
            13: begin r = a - 1;      c = (a < 1); end
            21: begin r = a - b;      c = (a < b); wr = 1'b0; end
            25: begin r = 0 - a;      c = (a != 0); end
            27: begin r = a - b - ci; c = (a < b + ci); end
            5:  r = a & b;
            6:  r = a & d;
            7:  r = a | b;
            8:  r = a | d;
            9:  r = a ^ b;
            10: r = a ^ d;
            11: r = ~a;
            14: begin r = a << n; c = (n != 0) && (((a >> (16 - n)) & 1) != 0); end
            15: begin r = a >> n; c = (n != 0) && (((a >> (n - 1)) & 1) != 0); end
            16: begin
                s = (a >= 32768) ? int'(a) - 65536 : int'(a);
                r = unsigned'(s >>> n);
                c = (n != 0) && (((a >> (n - 1)) & 1) != 0);
            end
            17: r = (a << n) | (a >> (16 - n));
            18: r = (a >> n) | (a << (16 - n));
            19: r = b;
            20: r = d;
            22: r = d;
            28: begin
                p = longint'(a) * longint'(b);
                r = int'(p & 64'hFFFF);
                c = ((p >> 16) != 0);
            end
            23: begin m_dm  = a[15:0]; wr = 1'b0; fl = 1'b0; end
            24: begin m_out = a[15:0]; wr = 1'b0; fl = 1'b0; end
            default: begin wr = 1'b0; fl = 1'b0; end
        endcase
        if (wr) m_ans = r[15:0];
        if (fl) begin
            m_c = c;
            m_z = (r[15:0] == 16'h0000);
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ans"},  ans_ex,   m_ans);
        chk({tag, "_dm"},   DM_data,  m_dm);
        chk({tag, "_out"},  data_out, m_out);
        chk({tag, "_flag"}, {14'h0, flag_ex}, {14'h0, m_c, m_z});
    endtask

    task automatic do_op(input string tag, input logic [5:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] d);
        op_dec = op; A = a; B = b; data_in = d;
        @(posedge clk);
        #1;
        model_step(op, a, b, d);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all({tag, "_hold"});
        reset = 1'b1;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0; A = '0; B = '0; data_in = '0; op_dec = '0;
        model_reset();
        #2;
        check_all("por");

        // Run a little, then reset mid-run and release.
        @(negedge clk); reset = 1'b1;
        do_op("pre_add", 6'd1, 16'h1111, 16'h2222, 16'h0);
        async_reset("mid_rst");

        do_op("adi", 6'd2, 16'd5, 16'd0, 16'd4);
        chk("adi_lit", ans_ex, 16'd9);
        chk("adi_flag_lit", {14'h0, flag_ex}, 16'h0000);

        do_op("mul1", 6'd28, 16'd5, 16'd2, 16'h0);
        chk("mul1_lit", ans_ex, 16'h000A);
        do_op("mul2", 6'd28, 16'h0100, 16'h0100, 16'h0);
        chk("mul2_flag_lit", {14'h0, flag_ex}, 16'h0003);

        do_op("add_wrap", 6'd1, 16'hFFFF, 16'h0001, 16'h0);
        chk("add_wrap_flag_lit", {14'h0, flag_ex}, 16'h0003);
        do_op("adc", 6'd26, 16'h0001, 16'h0001, 16'h0);
        chk("adc_lit", ans_ex, 16'd3);

        do_op("sub", 6'd3, 16'd3, 16'd5, 16'h0);
        chk("sub_lit", ans_ex, 16'hFFFE);
        chk("sub_flag_lit", {14'h0, flag_ex}, 16'h0002);
        do_op("cmp", 6'd21, 16'd7, 16'd7, 16'h0);
        chk("cmp_ans_lit", ans_ex, 16'hFFFE);
        chk("cmp_flag_lit", {14'h0, flag_ex}, 16'h0001);

        do_op("st", 6'd23, 16'h1234, 16'h0, 16'h0);
        chk("st_lit", DM_data, 16'h1234);
        do_op("out", 6'd24, 16'hBEEF, 16'h0, 16'h0);
        chk("out_lit", data_out, 16'hBEEF);
        do_op("rsvd", 6'd40, 16'h5555, 16'hAAAA, 16'h7777);

        do_op("shl", 6'd14, 16'h8001, 16'd1, 16'h0);
        chk("shl_lit", ans_ex, 16'h0002);
        do_op("sra", 6'd16, 16'h8000, 16'd4, 16'h0);
        chk("sra_lit", ans_ex, 16'hF800);
        do_op("dec0", 6'd13, 16'h0000, 16'h0, 16'h0);
        do_op("sbb", 6'd27, 16'h0005, 16'h0005, 16'h0);
        do_op("neg0", 6'd25, 16'h0000, 16'h0, 16'h0);
        do_op("shr0", 6'd15, 16'h1234, 16'h0010, 16'h0);
        async_reset("stream_rst");
        chk("stream_rst_lit", ans_ex, 16'h0000);

        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) < 8) op = 6'($urandom_range(0, 28));
            else op = 6'($urandom_range(0, 63));
            do_op($sformatf("rnd%0d_op%0d", i, op), op, pick_operand(), pick_operand(),
                  pick_operand());
            if (i == 300) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
